// File: rtl/tmu_fmlarb.sv
// tmu_fmlarb: two-master round-robin FML read arbiter, one 4-beat burst per grant
module tmu_fmlarb #(
    parameter int fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    output logic                 m0_ack,
    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    output logic                 m1_ack,
    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    input  logic                 fml_ack,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, REQ, TAIL} state_t;
    state_t               r_state;
    logic                 r_grant;
    logic                 r_last;
    logic                 r_stb;
    logic                 r_busy;
    logic [1:0]           r_tcount;
    logic [fml_depth-1:0] r_adr;
    logic                 w_pick;
    always_comb w_pick = (m0_stb && m1_stb) ? ~r_last : ~m0_stb;
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state  <= IDLE;
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_stb    <= 1'b0;
            r_busy   <= 1'b0;
            r_tcount <= '0;
            r_adr    <= '0;
        end else begin
            case (r_state)
                IDLE: if (m0_stb || m1_stb) begin
                    r_grant <= w_pick;
                    r_adr   <= w_pick ? m1_adr : m0_adr;
                    r_stb   <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= REQ;
                end
                REQ: if (fml_ack) begin
                    r_last   <= r_grant;
                    r_tcount <= '0;
                    r_stb    <= 1'b0;
                    r_state  <= TAIL;
                end
                TAIL: begin
                    r_tcount <= r_tcount + 2'd1;
                    if (r_tcount == 2'd2) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign fml_adr = r_adr;
    assign fml_stb = r_stb;
    assign busy    = r_busy;
    assign m0_ack  = fml_ack && r_state == REQ && !r_grant;
    assign m1_ack  = fml_ack && r_state == REQ && r_grant;
endmodule

// File: tb/tb_tmu_fmlarb.sv
// tb_tmu_fmlarb: randomized masters/slave checked against a transaction-timestamp model
module tb_tmu_fmlarb;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        m0_stb = 1'b0, m1_stb = 1'b0, fml_ack = 1'b0;
    logic        m0_ack, m1_ack, fml_stb, busy;
    logic [25:0] m0_adr = '0, m1_adr = '0, fml_adr;
    int          n_chk = 0, n_pass = 0;
    int          owner = -1, ack_cyc = -1, last = 1, age = 0, cyc = 0;
    logic [25:0] madr = '0;
    bit          req [2];
    logic [25:0] adr [2];
    bit          pa [2];
    int          p_req, p_spur, p_rst, p_drop, delay, phase;
    int          n_acks, last_ack, rr_next, n_m0;
    always #5 sys_clk = ~sys_clk;
    tmu_fmlarb dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_ack(m0_ack),
        .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_ack(m1_ack),
        .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_ack(fml_ack), .busy(busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        else n_pass++;
    endtask
    function automatic bit in_req();
        return owner >= 0 && ack_cyc < 0;
    endfunction
    function automatic logic [25:0] rand_adr();
        return 26'($urandom) & 26'h3FF_FFE0;
    endfunction
    task automatic model_update();
        if (sys_rst) begin
            owner = -1; ack_cyc = -1; madr = '0; last = 1; age = 0;
        end else if (owner < 0) begin
            if (m0_stb || m1_stb) begin
                owner = (m0_stb && m1_stb) ? 1 - last : (m1_stb ? 1 : 0);
                madr  = owner == 1 ? m1_adr : m0_adr;
                age   = 0;
            end
        end else if (ack_cyc < 0) begin
            if (fml_ack) begin
                ack_cyc = cyc; last = owner;
            end else age++;
        end else if (cyc - ack_cyc == 3) begin
            owner = -1; ack_cyc = -1;
        end
        cyc++;
    endtask
    task automatic run(input int n, input bit do_rst);
        bit e0, e1;
        for (int i = 0; i < n; i++) begin
            sys_rst = (do_rst && i == 0) || ($urandom_range(999) < p_rst);
            for (int k = 0; k < 2; k++) begin
                if (sys_rst) begin
                    req[k] = 1'b0; pa[k] = 1'b0;
                end else if (pa[k] || !req[k]) begin
                    req[k] = $urandom_range(99) < p_req;
                    if (req[k]) adr[k] = rand_adr();
                end else if ($urandom_range(999) < p_drop) req[k] = 1'b0;
            end
            m0_stb = req[0]; m0_adr = adr[0];
            m1_stb = req[1]; m1_adr = adr[1];
            fml_ack = (in_req() && (delay >= 0 ? age == delay : $urandom_range(2) == 0))
                      || ($urandom_range(99) < p_spur);
            @(negedge sys_clk);
            e0 = in_req() && fml_ack && owner == 0;
            e1 = in_req() && fml_ack && owner == 1;
            if (cyc > 0) begin
                check("fml_stb", 32'(fml_stb), 32'(in_req()));
                check("busy", 32'(busy), 32'(owner >= 0));
                check("fml_adr", 32'(fml_adr), 32'(madr));
                check("m0_ack", 32'(m0_ack), 32'(e0));
                check("m1_ack", 32'(m1_ack), 32'(e1));
            end
            if (phase == 2 && (m0_ack || m1_ack)) begin
                check("rr_grant", 32'(m1_ack), 32'(rr_next));
                if (n_acks > 0) check("burst_gap", 32'(cyc - last_ack), 32'd5);
                rr_next ^= 1; last_ack = cyc; n_acks++;
            end
            if (phase == 1) n_m0 += int'(m0_ack);
            pa[0] = e0; pa[1] = e1;
            @(posedge sys_clk);
            model_update();
            #1;
        end
    endtask
    initial begin
        adr[0] = '0; adr[1] = '0;
        phase = 1; p_req = 0; p_spur = 0; p_rst = 0; p_drop = 0; delay = 3; n_m0 = 0;
        run(2, 1'b1);
        req[0] = 1'b1; adr[0] = 26'h000_1240;
        run(14, 1'b0);
        check("single_m0_acks", 32'(n_m0), 32'd1);
        phase = 2; p_req = 100; delay = 0; n_acks = 0; rr_next = 0; last_ack = 0;
        run(28, 1'b1);
        check("bursts", 32'(n_acks), 32'd6);
        phase = 3; p_req = 30; p_spur = 10; p_rst = 8; p_drop = 20; delay = -1;
        run(3000, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
